// File: rtl/sysbus_arbiter.sv
// Two-master round-robin arbiter for the shared Sysbus port. A grant covers a whole
// transaction: the request phase plus the full write-data or read-response burst.
module sysbus_arbiter #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned BURST_BEATS    = 8
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      m0_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] m0_req,
   input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
   output logic                      m0_reqack,
   output logic                      m0_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] m0_resp,
   output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
   input  logic                      m0_respack,

   input  logic                      m1_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] m1_req,
   input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
   output logic                      m1_reqack,
   output logic                      m1_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] m1_resp,
   output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
   input  logic                      m1_respack,

   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack,

   output logic                      busy,
   output logic                      grant
);

   localparam int unsigned CountWidth = $clog2(BURST_BEATS) + 1;
   localparam logic [CountWidth-1:0] LastBeat = CountWidth'(BURST_BEATS - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWdata, StResp} state_e;

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_q, last_d;
   logic [CountWidth-1:0] count_q, count_d;

   logic                      sel_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] sel_req;
   logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
   logic                      sel_respack;

   assign sel_reqcyc  = grant_q ? m1_reqcyc  : m0_reqcyc;
   assign sel_req     = grant_q ? m1_req     : m0_req;
   assign sel_reqtag  = grant_q ? m1_reqtag  : m0_reqtag;
   assign sel_respack = grant_q ? m1_respack : m0_respack;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      count_d     = count_q;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      m0_reqack   = 1'b0;
      m1_reqack   = 1'b0;
      m0_respcyc  = 1'b0;
      m1_respcyc  = 1'b0;
      m0_resp     = '0;
      m1_resp     = '0;
      m0_resptag  = '0;
      m1_resptag  = '0;

      unique case (state_q)
         StIdle: begin
            // Bus-side acks and response beats are ignored here.
            if (m0_reqcyc || m1_reqcyc) begin
               grant_d = (m0_reqcyc && m1_reqcyc) ? ~last_q : m1_reqcyc;
               state_d = StReq;
            end
         end

         StReq: begin
            bus_reqcyc = sel_reqcyc;
            bus_req    = sel_req;
            bus_reqtag = sel_reqtag;
            m0_reqack  = ~grant_q & bus_reqack;
            m1_reqack  = grant_q & bus_reqack;
            if (!sel_reqcyc) begin
               state_d = StIdle;
            end else if (bus_reqack) begin
               count_d = '0;
               state_d = sel_reqtag[BUS_TAG_WIDTH-1] ? StResp : StWdata;
            end
         end

         StWdata: begin
            bus_reqcyc = sel_reqcyc;
            bus_req    = sel_req;
            bus_reqtag = sel_reqtag;
            m0_reqack  = ~grant_q & bus_reqack;
            m1_reqack  = grant_q & bus_reqack;
            if (sel_reqcyc && bus_reqack) begin
               count_d = count_q + 1'b1;
               if (count_q == LastBeat) begin
                  state_d = StIdle;
                  last_d  = grant_q;
               end
            end
         end

         StResp: begin
            bus_respack = sel_respack;
            if (grant_q) begin
               m1_respcyc = bus_respcyc;
               m1_resp    = bus_resp;
               m1_resptag = bus_resptag;
            end else begin
               m0_respcyc = bus_respcyc;
               m0_resp    = bus_resp;
               m0_resptag = bus_resptag;
            end
            if (bus_respcyc && sel_respack) begin
               count_d = count_q + 1'b1;
               if (count_q == LastBeat) begin
                  state_d = StIdle;
                  last_d  = grant_q;
               end
            end
         end

         default: state_d = StIdle;
      endcase

      // Outputs are held low for as long as reset is asserted, not just after the edge.
      if (!reset) begin
         bus_reqcyc  = 1'b0;
         bus_req     = '0;
         bus_reqtag  = '0;
         bus_respack = 1'b0;
         m0_reqack   = 1'b0;
         m1_reqack   = 1'b0;
         m0_respcyc  = 1'b0;
         m1_respcyc  = 1'b0;
         m0_resp     = '0;
         m1_resp     = '0;
         m0_resptag  = '0;
         m1_resptag  = '0;
      end
   end

   assign busy  = reset & (state_q != StIdle);
   assign grant = reset & grant_q;

endmodule
